// File: rtl/memory_weight_pkg.sv
// Shared sizing for the weight store, the weight loader and the MAC stage.
package memory_weight_pkg;
  localparam int WEIGHT_DATA_W = 8;
  localparam int WEIGHT_ADDR_W = 4;
  localparam int WEIGHT_DEPTH  = 16;
endpackage

// File: rtl/memory_weight.sv
// Weight store: DEPTH words, one write or read per clock, registered read port.
// A write also drives its data onto out; out-of-range accesses leave memory alone and return 0.
module memory_weight
  import memory_weight_pkg::*;
#(
  parameter int DATA_W = WEIGHT_DATA_W,
  parameter int ADDR_W = WEIGHT_ADDR_W,
  parameter int DEPTH  = WEIGHT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  output logic [DATA_W-1:0] out
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] out_q, out_d;
  logic              in_range;

  assign in_range = ({1'b0, addr} < DEPTH_L);

  always_comb begin
    mem_d = mem_q;
    if (wr && in_range) begin
      mem_d[addr] = data;
    end
  end

  always_comb begin
    out_d = '0;
    if (in_range) begin
      out_d = wr ? data : mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_memory_weight.sv
// Scoreboard bench: a full-depth store and a DEPTH=12 store share one stimulus stream.
module tb_memory_weight;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    int            addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] addr = '0;
  logic          wr = 1'b0;
  logic [DW-1:0] out_a, out_b;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  memory_weight #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .wr(wr), .out(out_a)
  );

  memory_weight #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .wr(wr), .out(out_b)
  );

  always #5 clk = ~clk;

  // Monitor: each registered result is checked just after the edge that produced it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (out_a !== e.exp_a || out_b !== e.exp_b) begin
        n_err++;
        $display("FAIL out@addr%0d: depth16 got %h want %h, depth12 got %h want %h",
                 e.addr, out_a, e.exp_a, out_b, e.exp_b);
      end
    end
  end

  task automatic op(input logic w, input int a, input logic [DW-1:0] d,
                    input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    exp_t e;
    @(negedge clk);
    wr   = w;
    addr = AW'(a);
    data = d;
    e.exp_a = ea;
    e.exp_b = eb;
    e.addr  = a;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string name);
    n_vec++;
    if (out_a !== '0 || out_b !== '0) begin
      n_err++;
      $display("FAIL %s: depth16 got %h depth12 got %h want 00", name, out_a, out_b);
    end
  endtask

  initial begin
    // 1: asynchronous reset mid-cycle, then every address reads 0
    #7 rst_n = 1'b0;
    #1 check_now("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) op(1'b0, i, 8'h00, 8'h00, 8'h00);

    // 2: writes then reads
    op(1'b1, 0, 8'h01, 8'h01, 8'h01);
    op(1'b1, 1, 8'h02, 8'h02, 8'h02);
    op(1'b1, 2, 8'h03, 8'h03, 8'h03);
    op(1'b0, 0, 8'hFF, 8'h01, 8'h01);
    op(1'b0, 1, 8'hFF, 8'h02, 8'h02);
    op(1'b0, 2, 8'hFF, 8'h03, 8'h03);

    // 3: overwrite
    op(1'b1, 1, 8'h04, 8'h04, 8'h04);
    op(1'b0, 1, 8'h00, 8'h04, 8'h04);
    op(1'b0, 0, 8'h00, 8'h01, 8'h01);
    op(1'b0, 2, 8'h00, 8'h03, 8'h03);

    // 4: reset between edges mid-operation
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_now("reset_midop");
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 1, 8'h00, 8'h00, 8'h00);
    op(1'b0, 0, 8'h00, 8'h00, 8'h00);

    // 5: boundaries; depth12 drops addresses 12..15
    op(1'b1, 11, 8'h11, 8'h11, 8'h11);
    op(1'b1, 15, 8'hAA, 8'hAA, 8'h00);
    op(1'b0, 15, 8'h00, 8'hAA, 8'h00);
    op(1'b1, 13, 8'h55, 8'h55, 8'h00);
    op(1'b0, 13, 8'h00, 8'h55, 8'h00);
    op(1'b1, 12, 8'h66, 8'h66, 8'h00);
    op(1'b0, 12, 8'h00, 8'h66, 8'h00);
    for (int i = 0; i < 12; i++)
      op(1'b0, i, 8'h00, (i == 11) ? 8'h11 : 8'h00, (i == 11) ? 8'h11 : 8'h00);

    // 6: write then read on consecutive edges
    op(1'b1, 5, 8'h7E, 8'h7E, 8'h7E);
    op(1'b0, 5, 8'h00, 8'h7E, 8'h7E);
    op(1'b0, 6, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    wr = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
